sync_fifo: RTL and testbench

SYNC_FIFO -- requirements
Module: sync_fifo

---
 rtl/sync_fifo_pkg.sv | 15 +
 rtl/sync_fifo_if.sv | 36 +++
 rtl/sync_fifo_mem.sv | 51 +++++
 rtl/sync_fifo.sv | 98 +++++++++
 tb/tb_sync_fifo.sv | 155 +++++++++++++++
 5 files changed

// File: rtl/sync_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_pkg
// Description : Default sizing constants shared by the synchronous FIFO,
//               its storage sub-module and its bus interface.
// Revision    : 1.0 - initial release
// ============================================================================
package sync_fifo_pkg;

    localparam int c_DATA_WIDTH = 16;
    localparam int c_DEPTH      = 8;
    localparam int c_ADDR_WIDTH = 3;

endpackage : sync_fifo_pkg
`default_nettype wire

// File: rtl/sync_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_if
// Description : Write/read handshake bundle of the synchronous FIFO.
//               master : wr_en, rd_en, wr_data out; rd_data, full, empty,
//                        count in (the FIFO user)
//               slave  : the FIFO side of the same signals
// Revision    : 1.0 - initial release
// ============================================================================
interface sync_fifo_if
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int ADDR_WIDTH = c_ADDR_WIDTH
);

    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] wr_data;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  full;
    logic                  empty;
    logic [ADDR_WIDTH:0]   count;

    modport master (
        output wr_en, rd_en, wr_data,
        input  rd_data, full, empty, count
    );

    modport slave (
        input  wr_en, rd_en, wr_data,
        output rd_data, full, empty, count
    );

endinterface : sync_fifo_if
`default_nettype wire

// File: rtl/sync_fifo_mem.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo_mem
// Description : DEPTH x DATA_WIDTH storage, one synchronous write port and
//               one synchronous read port with a registered output.
//               clk, rst_n           : clock, async active-low reset
//               wr_en_i/addr/data    : write port
//               rd_en_i/rd_addr_i    : read port
//               rd_data_o            : registered read data, holds when idle
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo_mem
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int DEPTH      = c_DEPTH,
    parameter int ADDR_WIDTH = c_ADDR_WIDTH
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  wr_en_i,
    input  wire logic [ADDR_WIDTH-1:0] wr_addr_i,
    input  wire logic [DATA_WIDTH-1:0] wr_data_i,
    input  wire logic                  rd_en_i,
    input  wire logic [ADDR_WIDTH-1:0] rd_addr_i,
    output logic      [DATA_WIDTH-1:0] rd_data_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rd_data_q;

    // Storage array carries no reset so it can map onto RAM.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    // Output register is cleared by reset so rd_data reads 0 after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule : sync_fifo_mem
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO, one-cycle registered read latency
//               (no first-word fall-through). Writes at full and reads at
//               empty are dropped silently.
//               clk   : clock, rising edge
//               rst_n : asynchronous active-low reset
//               bus   : sync_fifo_if.slave (wr_en, rd_en, wr_data, rd_data,
//                       full, empty, count)
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = c_DATA_WIDTH,
    parameter int DEPTH      = c_DEPTH,
    parameter int ADDR_WIDTH = c_ADDR_WIDTH
) (
    input  wire logic  clk,
    input  wire logic  rst_n,
    sync_fifo_if.slave bus
);

    localparam logic [ADDR_WIDTH:0] c_FULL_COUNT = (ADDR_WIDTH + 1)'(DEPTH);

    generate
        if (DEPTH != (2 ** ADDR_WIDTH)) begin : g_bad_depth
            $error("sync_fifo: DEPTH must equal 2**ADDR_WIDTH");
        end
    endgenerate

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q,  count_d;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;

    // Flags decode straight from the registered count, so they move on the
    // same edge as the operation that changes it.
    assign w_full   = (count_q == c_FULL_COUNT);
    assign w_empty  = (count_q == '0);
    assign w_wr_acc = bus.wr_en && !w_full;
    assign w_rd_acc = bus.rd_en && !w_empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers are exactly ADDR_WIDTH bits, so +1 wraps DEPTH-1 to 0.
        if (w_wr_acc) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_rd_acc) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_wr_acc, w_rd_acc})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    sync_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk        (clk),
        .rst_n      (rst_n),
        .wr_en_i    (w_wr_acc),
        .wr_addr_i  (wr_ptr_q),
        .wr_data_i  (bus.wr_data),
        .rd_en_i    (w_rd_acc),
        .rd_addr_i  (rd_ptr_q),
        .rd_data_o  (bus.rd_data)
    );

    assign bus.full  = w_full;
    assign bus.empty = w_empty;
    assign bus.count = count_q;

endmodule : sync_fifo
`default_nettype wire

// File: tb/tb_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_sync_fifo
// Description : Self-checking bench for sync_fifo against a queue-based
//               reference model; directed fill/drain/wrap/simultaneous/
//               overflow/async-reset sequences followed by random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sync_fifo;
    import sync_fifo_pkg::*;

    localparam int DW    = 16;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    sync_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sync_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (AW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [DW-1:0] model_q [$];
    logic [DW-1:0] exp_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "/count"}, 32'(bus.count),   32'(model_q.size()));
        chk({tag, "/full"},  32'(bus.full),    32'(model_q.size() == DEPTH));
        chk({tag, "/empty"}, 32'(bus.empty),   32'(model_q.size() == 0));
        chk({tag, "/rd"},    32'(bus.rd_data), 32'(exp_rd));
    endtask

    // One clock: drive on the falling edge, update the model at the rising
    // edge from the occupancy seen before it, check 1 ns later.
    task automatic step(input logic wr, input logic rd, input logic [DW-1:0] d,
                        input string tag);
        int n;
        @(negedge clk);
        bus.wr_en   = wr;
        bus.rd_en   = rd;
        bus.wr_data = d;
        @(posedge clk);
        n = model_q.size();
        if (rd && n > 0) exp_rd = model_q.pop_front();
        if (wr && n < DEPTH) model_q.push_back(d);
        #1;
        check_outputs(tag);
    endtask

    task automatic write_n(input int n, input logic [DW-1:0] base, input string tag);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, base + DW'(i), tag);
    endtask

    task automatic read_n(input int n, input string tag);
        for (int i = 0; i < n; i++) step(1'b0, 1'b1, '0, tag);
    endtask

    initial begin
        bus.wr_en   = 1'b0;
        bus.rd_en   = 1'b0;
        bus.wr_data = '0;
        rst_n       = 1'b0;
        exp_rd      = '0;
        #2;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Fill with writes gated by not-full: 9 and 10 never land.
        for (int i = 1; i <= 10; i++)
            step(model_q.size() < DEPTH, 1'b0, DW'(i), "fill");
        chk("fill_count", 32'(bus.count), 32'd8);

        // Drain with reads gated by not-empty; rd_data ends holding 8.
        for (int i = 0; i < 10; i++)
            step(1'b0, model_q.size() > 0, '0, "drain");
        chk("drain_hold", 32'(bus.rd_data), 32'd8);

        // Ungated overflow then underflow.
        write_n(8, 16'h0300, "ovf_fill");
        step(1'b1, 1'b0, 16'hDEAD, "ovf");
        step(1'b1, 1'b0, 16'hBEEF, "ovf");
        read_n(8, "ovf_drain");
        step(1'b0, 1'b1, '0, "udf");
        step(1'b0, 1'b1, '0, "udf");

        // Pointer wrap.
        write_n(5, 16'h0100, "wrap_pre_wr");
        read_n(5, "wrap_pre_rd");
        write_n(8, 16'hA000, "wrap_wr");
        read_n(8, "wrap_rd");

        // Simultaneous read and write at count 3, full and empty.
        write_n(3, 16'h0200, "sim_pre");
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 16'h0210 + DW'(i), "sim_mid");
        chk("sim_mid_count", 32'(bus.count), 32'd3);
        write_n(5, 16'h0220, "sim_fill");
        step(1'b1, 1'b1, 16'h0230, "sim_full");
        chk("sim_full_count", 32'(bus.count), 32'd7);
        read_n(7, "sim_drain");
        step(1'b1, 1'b1, 16'h0240, "sim_empty");
        chk("sim_empty_count", 32'(bus.count), 32'd1);
        read_n(1, "sim_last");

        // Asynchronous reset between edges at count 5.
        write_n(7, 16'h00B0, "arst_wr");
        read_n(2, "arst_rd");
        @(negedge clk);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        #2;
        rst_n = 1'b0;
        model_q.delete();
        exp_rd = '0;
        #1;
        check_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b1, 1'b0, 16'h0055, "post_rst_wr");
        step(1'b0, 1'b1, '0, "post_rst_rd");

        // Random traffic, write-biased first half, read-biased second half.
        for (int i = 0; i < 400; i++) begin
            int wp;
            wp = (i < 200) ? 65 : 35;
            step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < (100 - wp),
                 DW'($urandom), "rand");
        end
        read_n(DEPTH + 1, "rand_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_sync_fifo
`default_nettype wire
